rf_wport_arbiter: RTL

- Arbitrates the single register-file write port between two sources: the pipeline writeback stage and a long-latency unit (mul/div) that returns results out of order.
- Holds at most one long-latency result in a buffer until the write port is free.
- Keeps a pending-destination scoreboard for hazard detection.
- Forces a pipeline stall when a buffered result has waited too long.

---
 rtl/rf_wport_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. one buffered long-latency result.
// Optional statistics counters are enabled by defining RF_ARB_STATS_EN.
module rf_wport_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wbEn,
  input  logic [4:0]  pipe_wd,
  input  logic [63:0] pipe_wbData,
  input  logic        lu_issue_en,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_wd,
  input  logic [63:0] lu_data,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [63:0] rf_wd,
  output logic        stall_req,
  output logic [31:0] pending_mask,
  output logic [31:0] stat_wait_cycles,
  output logic [31:0] stat_forced
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  localparam logic [1:0] GRANT_IDLE = 2'd0;
  localparam logic [1:0] GRANT_PIPE = 2'd1;
  localparam logic [1:0] GRANT_BUF  = 2'd2;

  logic        buf_full;
  logic [4:0]  buf_wd;
  logic [63:0] buf_data;
  logic [3:0]  wait_cnt;

  logic [1:0]  grant;
  logic        buf_win;
  logic [4:0]  win_addr;
  logic [63:0] win_data;
  logic        accept;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign lu_ready  = ~buf_full;
  assign stall_req = (wait_cnt == MAX_W) & buf_full;
  assign accept    = lu_valid & ~buf_full;
  assign buf_win   = (grant == GRANT_BUF);

  // Single winner per cycle; a forced grant overrides a waiting pipeline request.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant    = GRANT_IDLE;
    win_addr = rf_wa;
    win_data = rf_wd;
    if (stall_req) begin
      grant = GRANT_BUF;
    end else if (pipe_wbEn) begin
      grant = GRANT_PIPE;
    end else if (buf_full) begin
      grant = GRANT_BUF;
    end
    if (grant == GRANT_PIPE) begin
      win_addr = pipe_wd;
      win_data = pipe_wbData;
    end else if (grant == GRANT_BUF) begin
      win_addr = buf_wd;
      win_data = buf_data;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (lu_issue_en) set_mask[lu_issue_rd] = 1'b1;
    if (buf_win)     clr_mask[buf_wd]      = 1'b1;
    set_mask[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we        <= 1'b0;
      rf_wa        <= '0;
      rf_wd        <= '0;
      buf_full     <= 1'b0;
      wait_cnt     <= '0;
      pending_mask <= '0;
    end else begin
      rf_we <= (grant != GRANT_IDLE) && (win_addr != 5'd0);
      if (grant != GRANT_IDLE) begin
        rf_wa <= win_addr;
        rf_wd <= win_data;
      end

      if (buf_win) begin
        buf_full <= 1'b0;
      end else if (accept && (lu_wd != 5'd0)) begin
        buf_full <= 1'b1;
      end

      if (!buf_full || buf_win) begin
        wait_cnt <= '0;
      end else if (wait_cnt != MAX_W) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      pending_mask <= ((pending_mask & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end
  end

  // NOTE: buffer payload has no reset; buf_full alone qualifies it.
  always_ff @(posedge clk) begin
    if (accept && (lu_wd != 5'd0)) begin
      buf_wd   <= lu_wd;
      buf_data <= lu_data;
    end
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_wait_cycles <= '0;
      stat_forced      <= '0;
    end else begin
      if (buf_full && !buf_win) stat_wait_cycles <= stat_wait_cycles + 32'd1;
      if (stall_req)            stat_forced      <= stat_forced + 32'd1;
    end
  end
`else
  assign stat_wait_cycles = '0;
  assign stat_forced      = '0;
`endif

endmodule
